btn_debounce_array: RTL and testbench
=====================================

BTN_DEBOUNCE_ARRAY -- requirements
Module: btn_debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 SHALL have parameter STABLE_CYC, default 1000000: consecutive stable synchronized samples required to accept a level change, minimum 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means a pressed button reads 0 at the pin; 0 means a pressed button reads 1.
REQ-004 SHALL have parameter LONG_CYC, default 50000000: pressed cycles from btn_press to the first btn_hold pulse, minimum 2.
REQ-005 SHALL have parameter REPEAT_CYC, default 10000000: cycles between repeat btn_hold pulses while held; 0 disables repeat.
REQ-006 SHALL provide port `clk  input  1`: sole clock, rising-edge.
REQ-007 SHALL provide port `rst  input  1`: synchronous, active-high reset.
REQ-008 SHALL provide port `btn  input  N_CH`: raw asynchronous button pins, possibly bouncing.
REQ-009 SHALL provide port `btn_level  output  N_CH`: debounced pressed state, 1 = pressed, independent of ACTIVE_LOW.
REQ-010 SHALL provide port `btn_press  output  N_CH`: one-cycle pulse on an accepted press.
REQ-011 SHALL provide port `btn_release  output  N_CH`: one-cycle pulse on an accepted release.
REQ-012 SHALL provide port `btn_hold  output  N_CH`: one-cycle long-press and auto-repeat pulses.
REQ-013 SHALL provide port `any_press  output  1`: OR of all btn_press bits, same cycle.

Function
REQ-014 Each channel SHALL pass its btn bit through a 2-FF synchronizer, then invert it if ACTIVE_LOW=1, giving the sample s.
REQ-015 Each channel SHALL hold a stable counter of width $clog2(STABLE_CYC+1) that counts consecutive cycles where s differs from btn_level.
REQ-016 The stable counter SHALL clear to 0 on any cycle where s equals btn_level, so a glitch shorter than STABLE_CYC cycles never changes btn_level.
REQ-017 On the STABLE_CYC-th consecutive differing sample, btn_level SHALL toggle and the counter SHALL clear in the same edge.
REQ-018 Latency: after the pin settles, btn_level SHALL change on the (STABLE_CYC+2)-th rising edge, counting the first edge that samples the new pin value as edge 1.
REQ-019 btn_press SHALL be 1 for exactly the one cycle in which btn_level first reads 1; btn_release likewise for the first cycle btn_level reads 0.
REQ-020 Outputs SHALL be registered, with no combinational path from btn to any output.
REQ-021 Each channel SHALL have a per-channel hold FSM with states IDLE, WAIT_LONG and REPEAT.
REQ-022 Hold FSM, IDLE: go to WAIT_LONG with the hold counter at 0 on the press edge.
REQ-023 Hold FSM, WAIT_LONG: count while pressed; pulse btn_hold when LONG_CYC cycles have elapsed since the btn_press cycle; then enter REPEAT if REPEAT_CYC>0, else stay parked in WAIT_LONG with the counter saturated.
REQ-024 Hold FSM, REPEAT: pulse btn_hold every REPEAT_CYC cycles after the previous pulse.
REQ-025 In any hold-FSM state, btn_level falling SHALL return the FSM to IDLE and clear its counter in the same edge, with no btn_hold pulse in that cycle.
REQ-026 Hold counter width SHALL be $clog2(max(LONG_CYC,REPEAT_CYC)+1), and the counter SHALL never wrap.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-028 btn_press and btn_release on the same channel SHALL never assert in the same cycle.
REQ-029 btn_hold SHALL never coincide with btn_press on the same channel, since LONG_CYC>=2.

Reset
REQ-030 While rst=1 at a clock edge, the synchronizer flops SHALL load the inactive pin level (1 if ACTIVE_LOW=1, else 0).
REQ-031 While rst=1 at a clock edge, all counters SHALL be 0, hold FSMs SHALL be IDLE, and btn_level, btn_press, btn_release, btn_hold and any_press SHALL all be 0.
REQ-032 Reset asserted mid-count or mid-hold SHALL abort the operation at that edge, with no pulse on the reset edge or the first edge after release.
REQ-033 A button held pressed through reset release SHALL be accepted as a normal new press, with btn_press STABLE_CYC+2 edges after release.

Verification (N_CH=2, STABLE_CYC=4, ACTIVE_LOW=1, LONG_CYC=10, REPEAT_CYC=5, 10 ns clock)
REQ-034 Bounce test: drive btn[0] alternating 0/1 every 3 ns for 30 ns, then 1 -> btn_level[0], btn_press[0] and btn_hold[0] stay 0 throughout.
REQ-035 Clean press test: drive btn[0]=0 just before edge k -> btn_level[0] rises and btn_press[0]=1 for one cycle at edge k+5; any_press=1 in that cycle only.
REQ-036 Short-glitch test: with btn[1] pressed, drive a 3-cycle high pulse on btn[1] -> no btn_release[1]; a 5-cycle high pulse -> btn_release[1] is a single cycle and btn_level[1]=0.
REQ-037 Long-hold test: hold btn[0] for 30 cycles after btn_press -> btn_hold[0] pulses at press+10, +15, +20, +25, +30; after release, btn_release[0] fires and there are no further btn_hold pulses.
REQ-038 Reset-during-hold test: assert rst for 2 cycles at press+7 with btn still low -> all outputs read 0 during reset; btn_press recurs 6 edges after rst deasserts and btn_hold follows 10 cycles after that.
REQ-039 Dual-channel test: press both channels on the same edge -> btn_press=2'b11 in a single cycle, and any_press asserts for one cycle only.

Source files
------------

// File: rtl/btn_debounce_array.sv
// Multi-channel button conditioner: 2-FF synchronizer, stable-count debounce,
// press/release edge pulses and long-press / auto-repeat hold pulses per channel.
// Hold FSM:  state        | meaning
//            ST_IDLE      | released, hold counter idle
//            ST_WAIT_LONG | pressed, counting toward the first hold pulse (or parked)
//            ST_REPEAT    | pressed past LONG_CYC, pulsing every REPEAT_CYC cycles
module btn_debounce_array #(
    parameter int N_CH       = 4,
    parameter int STABLE_CYC = 1000000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int LONG_CYC   = 50000000,
    parameter int REPEAT_CYC = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_hold,
    output logic            any_press
);

    localparam int SW   = $clog2(STABLE_CYC + 1);
    localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LONG = 2'd1;
    localparam logic [1:0] ST_REPEAT    = 2'd2;

    localparam logic [N_CH-1:0] INACTIVE = {N_CH{ACTIVE_LOW}};

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_s;
    logic [N_CH-1:0] w_rise_v;
    logic            r_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= INACTIVE;
            r_sync2 <= INACTIVE;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SW-1:0] r_stab;
        logic [HW-1:0] r_hcnt;
        logic [1:0]    r_state;
        logic          r_lvl;
        logic          r_prs;
        logic          r_rel;
        logic          r_hld;
        logic          w_toggle;
        logic          w_rise;
        logic          w_fall;

        assign w_toggle    = (w_s[g] != r_lvl) && (r_stab == SW'(STABLE_CYC - 1));
        assign w_rise      = w_toggle && !r_lvl;
        assign w_fall      = w_toggle && r_lvl;
        assign w_rise_v[g] = w_rise;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_stab <= '0;
                r_lvl  <= 1'b0;
                r_prs  <= 1'b0;
                r_rel  <= 1'b0;
            end else begin
                r_prs <= w_rise;
                r_rel <= w_fall;
                if (w_s[g] == r_lvl || w_toggle) begin
                    r_stab <= '0;
                end else begin
                    r_stab <= r_stab + SW'(1);
                end
                if (w_toggle) begin
                    r_lvl <= ~r_lvl;
                end
            end
        end

        // A falling level always wins so no hold pulse can share the release edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
                r_hld   <= 1'b0;
            end else begin
                r_hld <= 1'b0;
                if (w_fall) begin
                    r_state <= ST_IDLE;
                    r_hcnt  <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_rise) begin
                                r_state <= ST_WAIT_LONG;
                                r_hcnt  <= '0;
                            end
                        end
                        ST_WAIT_LONG: begin
                            if (r_hcnt == HW'(LONG_CYC - 1)) begin
                                r_hld <= 1'b1;
                                if (REPEAT_CYC > 0) begin
                                    r_state <= ST_REPEAT;
                                    r_hcnt  <= '0;
                                end else begin
                                    r_hcnt  <= HW'(LONG_CYC);
                                end
                            end else if (r_hcnt != HW'(LONG_CYC)) begin
                                r_hcnt <= r_hcnt + HW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (r_hcnt == HW'(REPEAT_CYC - 1)) begin
                                r_hld  <= 1'b1;
                                r_hcnt <= '0;
                            end else begin
                                r_hcnt <= r_hcnt + HW'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_hcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[g]   = r_lvl;
        assign btn_press[g]   = r_prs;
        assign btn_release[g] = r_rel;
        assign btn_hold[g]    = r_hld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_rise_v;
        end
    end

    assign any_press = r_any;

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array: two active-low channels, STABLE_CYC=4,
// LONG_CYC=10, REPEAT_CYC=5; every output is compared once per clock cycle.
module tb_btn_debounce_array;

    logic       clk;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_hold;
    logic       any_press;

    int n_assert = 0;
    int n_fail   = 0;

    btn_debounce_array #(
        .N_CH       (2),
        .STABLE_CYC (4),
        .ACTIVE_LOW (1'b1),
        .LONG_CYC   (10),
        .REPEAT_CYC (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .any_press   (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic [1:0] lv,
                       input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] hd);
        n_assert++;
        assert (btn_level === lv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d btn_level observed=%b expected=%b", tag, e, btn_level, lv);
        end
        n_assert++;
        assert (btn_press === pr) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d btn_press observed=%b expected=%b", tag, e, btn_press, pr);
        end
        n_assert++;
        assert (btn_release === rl) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d btn_release observed=%b expected=%b", tag, e, btn_release, rl);
        end
        n_assert++;
        assert (btn_hold === hd) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d btn_hold observed=%b expected=%b", tag, e, btn_hold, hd);
        end
        n_assert++;
        assert (any_press === (|pr)) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d any_press observed=%b expected=%b", tag, e, any_press, |pr);
        end
    endtask

    initial begin
        logic [1:0] lv, pr, rl, hd;
        rst = 1'b1;
        btn = 2'b11;

        // reset state
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("reset", e, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("idle", e, 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // bounce on channel 0: never accepted
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    btn[0] = i[0];
                    #3;
                end
                btn[0] = 1'b1;
            end
            begin
                for (int e = 1; e <= 14; e++) begin
                    step();
                    chk("bounce", e, 2'b00, 2'b00, 2'b00, 2'b00);
                end
            end
        join

        // clean press and long hold on channel 0, released after edge 33
        btn[0] = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            step();
            lv = {1'b0, (e >= 6 && e < 39)};
            pr = {1'b0, (e == 6)};
            rl = {1'b0, (e == 39)};
            hd = {1'b0, (e == 16 || e == 21 || e == 26 || e == 31 || e == 36)};
            chk("press_hold", e, lv, pr, rl, hd);
            if (e == 33) btn[0] = 1'b1;
        end

        // glitches on pressed channel 1: 3-cycle ignored, 5-cycle releases
        btn[1] = 1'b0;
        for (int e = 1; e <= 42; e++) begin
            step();
            lv = {((e >= 6 && e < 24) || (e >= 29 && e < 36)), 1'b0};
            pr = {(e == 6 || e == 29), 1'b0};
            rl = {(e == 24 || e == 36), 1'b0};
            hd = {(e == 16 || e == 21), 1'b0};
            chk("glitch", e, lv, pr, rl, hd);
            if (e == 8)  btn[1] = 1'b1;
            if (e == 11) btn[1] = 1'b0;
            if (e == 18) btn[1] = 1'b1;
            if (e == 23) btn[1] = 1'b0;
            if (e == 30) btn[1] = 1'b1;
        end

        // reset for two edges mid-hold with the button kept pressed
        btn[0] = 1'b0;
        for (int e = 1; e <= 42; e++) begin
            step();
            lv = {1'b0, ((e >= 6 && e < 13) || (e >= 20 && e < 38))};
            pr = {1'b0, (e == 6 || e == 20)};
            rl = {1'b0, (e == 38)};
            hd = {1'b0, (e == 30 || e == 35)};
            chk("rst_hold", e, lv, pr, rl, hd);
            if (e == 12) rst = 1'b1;
            if (e == 14) rst = 1'b0;
            if (e == 32) btn[0] = 1'b1;
        end

        // both channels pressed and released together
        btn = 2'b00;
        for (int e = 1; e <= 16; e++) begin
            step();
            lv = (e >= 6 && e < 13) ? 2'b11 : 2'b00;
            pr = (e == 6)  ? 2'b11 : 2'b00;
            rl = (e == 13) ? 2'b11 : 2'b00;
            chk("dual", e, lv, pr, rl, 2'b00);
            if (e == 7) btn = 2'b11;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
